// File: rtl/frontend_pkg.sv
// Shared constants for the two-cycle RV32I frontend: opcodes, 74x381 S codes, idle output words, FSM encoding.
// The HALT state encoding exists only when FRONTEND_HALT_EN is defined.
package frontend_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] S_CLR = 3'b000;
    localparam logic [2:0] S_SUB = 3'b010;  // A minus B
    localparam logic [2:0] S_ADD = 3'b011;
    localparam logic [2:0] S_XOR = 3'b100;
    localparam logic [2:0] S_OR  = 3'b101;
    localparam logic [2:0] S_AND = 3'b110;

    // Upper five alu_op bits {slt,sltu,sll,srl,sra}, active-low one-hot.
    localparam logic [4:0] FN_NONE = 5'b11111;
    localparam logic [4:0] FN_SLT  = 5'b01111;
    localparam logic [4:0] FN_SLTU = 5'b10111;
    localparam logic [4:0] FN_SLL  = 5'b11011;
    localparam logic [4:0] FN_SRL  = 5'b11101;
    localparam logic [4:0] FN_SRA  = 5'b11110;

    localparam logic [7:0] ALU_OP_IDLE = 8'hF8;
    localparam logic [7:0] MEM_OP_IDLE = 8'hFF;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
`ifdef FRONTEND_HALT_EN
    localparam logic [1:0] ST_HALT  = 2'd2;
`endif

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    // mem_op is {lb,lh,lw,lbu,lhu,sb,sh,sw}; unsupported widths stay idle.
    function automatic logic [7:0] load_mem_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return 8'b0111_1111;
            3'b001:  return 8'b1011_1111;
            3'b010:  return 8'b1101_1111;
            3'b100:  return 8'b1110_1111;
            3'b101:  return 8'b1111_0111;
            default: return MEM_OP_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] store_mem_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return 8'b1111_1011;
            3'b001:  return 8'b1111_1101;
            3'b010:  return 8'b1111_1110;
            default: return MEM_OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/frontend_gpr_file.sv
// 32x32 register file, two combinational read ports and one write port; x0 reads zero, writes to it are dropped.
// Latency: reads same cycle, write visible after the clock edge. Backpressure: none.
module gpr_file (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];

endmodule

// File: rtl/frontend.sv
// RV32I fetch/decode frontend driving a 74x381-style backend; FETCH/EXEC FSM, two cycles per instruction.
// Latency: decode drives the backend during EXEC, GPR write and PC update land on the EXEC edge. Backpressure: none.
// FRONTEND_HALT_EN adds a HALT state entered by ECALL/EBREAK/unknown opcodes; without it those are NOPs.
module frontend
    import frontend_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [7:0]  alu_op,
    output logic [7:0]  mem_op,
    output logic        load,
    output logic        store,
    output logic [31:0] alu_opr_1,
    output logic [31:0] alu_opr_2,
    output logic [31:0] rs2_data,
    input  logic [31:0] gpr_di,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic        halted
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        gpr_we;

    logic [31:0] rs1_val, rs2_val;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic        alt_op;

    logic [4:0]  dec_fn;
    logic [2:0]  dec_s;
    logic [7:0]  dec_mem_op;
    logic        dec_load, dec_store, dec_wr, br_taken;
    logic [31:0] dec_opr1, dec_opr2, next_pc;
    logic [4:0]  shamt;
    logic        exec_active;
`ifdef FRONTEND_HALT_EN
    logic        dec_halt;
`endif

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign funct3  = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign alt_op  = ir_q[30];

    gpr_file u_gpr (
        .clk (clk),
        .ra1 (rs1_idx),
        .ra2 (rs2_idx),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (gpr_we),
        .wa  (rd_idx),
        .wd  (gpr_di)
    );

    always_comb begin
        dec_fn     = FN_NONE;
        dec_s      = S_CLR;
        dec_mem_op = MEM_OP_IDLE;
        dec_load   = 1'b1;
        dec_store  = 1'b1;
        dec_wr     = 1'b0;
        dec_opr1   = 32'd0;
        dec_opr2   = 32'd0;
        br_taken   = 1'b0;
        shamt      = 5'd0;
        next_pc    = pc_q + 32'd4;
`ifdef FRONTEND_HALT_EN
        dec_halt   = 1'b0;
`endif
        case (opcode)
            OPC_LUI: begin
                dec_s    = S_ADD;
                dec_opr2 = imm_u(ir_q);
                dec_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s    = S_ADD;
                dec_opr1 = pc_q;
                dec_opr2 = imm_u(ir_q);
                dec_wr   = 1'b1;
            end
            OPC_JAL: begin
                dec_s    = S_ADD;
                dec_opr1 = pc_q;
                dec_opr2 = 32'd4;
                dec_wr   = 1'b1;
                next_pc  = pc_q + imm_j(ir_q);
            end
            OPC_JALR: begin
                // Target uses rs1 as read this cycle, before the link write lands.
                dec_s    = S_ADD;
                dec_opr1 = pc_q;
                dec_opr2 = 32'd4;
                dec_wr   = 1'b1;
                next_pc  = (rs1_val + imm_i(ir_q)) & ~32'd1;
            end
            OPC_BRANCH: begin
                dec_s    = S_SUB;
                dec_opr1 = rs1_val;
                dec_opr2 = rs2_val;
                case (funct3)
                    3'b000:  br_taken = ~is_zero;
                    3'b001:  br_taken = is_zero;
                    3'b100:  br_taken = ~is_lt;
                    3'b101:  br_taken = is_lt;
                    3'b110:  br_taken = ~is_ltu;
                    3'b111:  br_taken = is_ltu;
                    default: br_taken = 1'b0;
                endcase
                if (br_taken) begin
                    next_pc = pc_q + imm_b(ir_q);
                end
            end
            OPC_LOAD: begin
                dec_s      = S_ADD;
                dec_opr1   = rs1_val;
                dec_opr2   = imm_i(ir_q);
                dec_mem_op = load_mem_op(funct3);
                dec_load   = (dec_mem_op == MEM_OP_IDLE);
                dec_wr     = ~dec_load;
            end
            OPC_STORE: begin
                dec_s      = S_ADD;
                dec_opr1   = rs1_val;
                dec_opr2   = imm_s(ir_q);
                dec_mem_op = store_mem_op(funct3);
                dec_store  = (dec_mem_op == MEM_OP_IDLE);
            end
            OPC_OP_IMM, OPC_OP: begin
                dec_wr   = 1'b1;
                dec_opr1 = rs1_val;
                dec_opr2 = (opcode == OPC_OP) ? rs2_val : imm_i(ir_q);
                shamt    = (opcode == OPC_OP) ? rs2_val[4:0] : rs2_idx;
                case (funct3)
                    3'b000:  dec_s = ((opcode == OPC_OP) && alt_op) ? S_SUB : S_ADD;
                    3'b010: begin
                        dec_fn = FN_SLT;
                        dec_s  = S_SUB;
                    end
                    3'b011: begin
                        dec_fn = FN_SLTU;
                        dec_s  = S_SUB;
                    end
                    3'b100:  dec_s = S_XOR;
                    3'b110:  dec_s = S_OR;
                    3'b111:  dec_s = S_AND;
                    3'b001: begin
                        dec_fn   = FN_SLL;
                        dec_opr2 = {27'd0, shamt};
                    end
                    default: begin
                        dec_fn   = alt_op ? FN_SRA : FN_SRL;
                        dec_opr2 = {27'd0, shamt};
                    end
                endcase
            end
            OPC_MISC_MEM: begin
            end
            OPC_SYSTEM: begin
`ifdef FRONTEND_HALT_EN
                dec_halt = 1'b1;
`endif
            end
            default: begin
`ifdef FRONTEND_HALT_EN
                dec_halt = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        gpr_we  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
`ifdef FRONTEND_HALT_EN
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = next_pc;
                    gpr_we  = dec_wr;
                    state_d = ST_FETCH;
                end
`else
                pc_d    = next_pc;
                gpr_we  = dec_wr;
                state_d = ST_FETCH;
`endif
            end
`ifdef FRONTEND_HALT_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if (rst) begin
            state_d = ST_FETCH;
            pc_d    = RESET_PC;
            ir_d    = NOP_INSN;
            gpr_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        ir_q    <= ir_d;
    end

    assign exec_active = (state_q == ST_EXEC) && !rst;

    assign imem_addr = pc_q;
    assign alu_op    = exec_active ? {dec_fn, dec_s} : ALU_OP_IDLE;
    assign mem_op    = exec_active ? dec_mem_op : MEM_OP_IDLE;
    assign load      = exec_active ? dec_load : 1'b1;
    assign store     = exec_active ? dec_store : 1'b1;
    assign alu_opr_1 = exec_active ? dec_opr1 : 32'd0;
    assign alu_opr_2 = exec_active ? dec_opr2 : 32'd0;
    assign rs2_data  = exec_active ? rs2_val : 32'd0;

`ifdef FRONTEND_HALT_EN
    assign halted = (state_q == ST_HALT) && !rst;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_frontend.sv
// Directed bench for frontend: reset, ALU/branch/jump/load/store decode, mid-EXEC reset and HALT.
module tb_frontend;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [7:0]  alu_op;
    logic [7:0]  mem_op;
    logic        load, store;
    logic [31:0] alu_opr_1, alu_opr_2, rs2_data;
    logic [31:0] gpr_di;
    logic        is_lt, is_ltu, is_zero;
    logic        halted;

    logic [31:0] rom [0:127];
    int          n_chk;
    int          n_pass;

    frontend #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .alu_op    (alu_op),
        .mem_op    (mem_op),
        .load      (load),
        .store     (store),
        .alu_opr_1 (alu_opr_1),
        .alu_opr_2 (alu_opr_2),
        .rs2_data  (rs2_data),
        .gpr_di    (gpr_di),
        .is_lt     (is_lt),
        .is_ltu    (is_ltu),
        .is_zero   (is_zero),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (imem_addr < 32'd512) imem_data = rom[7'(imem_addr >> 2)];
        else                     imem_data = 32'h0000_0013;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        for (int i = 0; i < 128; i++) rom[i] = 32'h0000_0013;
        rst = 1'b1;
        gpr_di = 32'd0;
        is_lt = 1'b1;
        is_ltu = 1'b1;
        is_zero = 1'b1;

        step();
        step();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_alu_op", alu_op, 8'hF8);
        chk("rst_mem_op", mem_op, 8'hFF);
        chk("rst_ldst", {load, store}, 2'b11);
        chk("rst_opr1", alu_opr_1, 32'h0);
        chk("rst_opr2", alu_opr_2, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ir", dut.ir_q, 32'h0000_0013);

        // Seed x8 and x3 so later no-write checks have known contents.
        rom[0] = 32'h0550_0413;   // addi x8,x0,0x55
        rom[1] = 32'h0110_0193;   // addi x3,x0,0x11
        rst = 1'b0;
        chk("fetch1_idle", alu_op, 8'hF8);
        step(); gpr_di = 32'h55;
        step();
        step(); gpr_di = 32'h11;
        step();
        chk("seed_x8", dut.u_gpr.regs_q[8], 32'h55);
        chk("seed_x3", dut.u_gpr.regs_q[3], 32'h11);

        rst = 1'b1;
        step();
        rom[0]  = 32'h0050_0093;  // addi x1,x0,5
        rom[1]  = 32'h0330_0113;  // addi x2,x0,0x33
        rom[2]  = 32'h0020_8863;  // beq x1,x2,+16
        rom[3]  = 32'h0020_8233;  // add x4,x1,x2
        rom[4]  = 32'h4020_8233;  // sub x4,x1,x2
        rom[5]  = 32'h0020_A233;  // slt x4,x1,x2
        rom[6]  = 32'h4030_D313;  // srai x6,x1,3
        rom[7]  = 32'h1000_0293;  // addi x5,x0,0x100
        rom[8]  = 32'h0032_82E7;  // jalr x5,x5,3
        rom[64] = 32'h0020_A423;  // sw x2,8(x1)   @0x102
        rom[65] = 32'h0040_A383;  // lw x7,4(x1)   @0x106
        rom[66] = 32'h0010_0073;  // ebreak        @0x10A
        rst = 1'b0;

        step();
        chk("addi_alu_op", alu_op, 8'hFB);
        chk("addi_opr1", alu_opr_1, 32'h0);
        chk("addi_opr2", alu_opr_2, 32'h5);
        gpr_di = 32'h5;
        step();
        chk("addi_x1", dut.u_gpr.regs_q[1], 32'h5);
        chk("addi_pc", imem_addr, 32'h4);
        step(); gpr_di = 32'h33;
        step();
        chk("addi2_pc", imem_addr, 32'h8);

        step();
        chk("beq_alu_op", alu_op, 8'hFA);
        chk("beq_opr1", alu_opr_1, 32'h5);
        chk("beq_opr2", alu_opr_2, 32'h33);
        is_zero = 1'b0;
        gpr_di = 32'hDEAD_BEEF;
        step();
        chk("beq_taken_pc", imem_addr, 32'h18);
        chk("beq_taken_nowr", dut.u_gpr.regs_q[8], 32'h55);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); gpr_di = 32'h5;
        step();
        step(); gpr_di = 32'h33;
        step();
        step(); is_zero = 1'b1; gpr_di = 32'hDEAD_BEEF;
        step();
        chk("beq_fall_pc", imem_addr, 32'hC);
        chk("beq_fall_nowr", dut.u_gpr.regs_q[8], 32'h55);

        step();
        chk("add_alu_op", alu_op, 8'hFB);
        chk("add_opr2", alu_opr_2, 32'h33);
        gpr_di = 32'h38;
        step();
        chk("add_x4", dut.u_gpr.regs_q[4], 32'h38);
        step();
        chk("sub_alu_op", alu_op, 8'hFA);
        step();
        step();
        chk("slt_alu_op", alu_op, 8'h7A);
        step();
        step();
        chk("srai_fn", alu_op[7:3], 5'b11110);
        chk("srai_opr1", alu_opr_1, 32'h5);
        chk("srai_opr2", alu_opr_2, 32'h3);
        step();
        step(); gpr_di = 32'h100;
        step();
        chk("x5_seed", dut.u_gpr.regs_q[5], 32'h100);

        step();
        chk("jalr_alu_op", alu_op, 8'hFB);
        chk("jalr_opr1", alu_opr_1, 32'h20);
        chk("jalr_opr2", alu_opr_2, 32'h4);
        gpr_di = 32'h24;
        step();
        chk("jalr_pc", imem_addr, 32'h102);
        chk("jalr_link", dut.u_gpr.regs_q[5], 32'h24);
        chk("sw_fetch_store", store, 1'b1);

        step();
        chk("sw_mem_op", mem_op, 8'hFE);
        chk("sw_ldst", {load, store}, 2'b10);
        chk("sw_opr1", alu_opr_1, 32'h5);
        chk("sw_opr2", alu_opr_2, 32'h8);
        chk("sw_rs2_data", rs2_data, 32'h33);
        gpr_di = 32'h0000_0BAD;
        step();
        chk("sw_after_store", store, 1'b1);
        chk("sw_nowr", dut.u_gpr.regs_q[8], 32'h55);
        chk("sw_pc", imem_addr, 32'h106);

        step();
        chk("lw_mem_op", mem_op, 8'hDF);
        chk("lw_ldst", {load, store}, 2'b01);
        gpr_di = 32'h1234;
        step();
        chk("lw_x7", dut.u_gpr.regs_q[7], 32'h1234);

        step();
        step();
`ifdef FRONTEND_HALT_EN
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc", imem_addr, 32'h10A);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_hold_pc", imem_addr, 32'h10A);
            chk("halt_hold_flag", halted, 1'b1);
            chk("halt_idle", mem_op, 8'hFF);
        end
`else
        chk("ebreak_nop_flag", halted, 1'b0);
        chk("ebreak_nop_pc", imem_addr, 32'h10E);
`endif

        rst = 1'b1;
        step();
        chk("rst2_halted", halted, 1'b0);
        rom[0] = 32'h0070_0193;   // addi x3,x0,7
        rst = 1'b0;
        step();
        chk("mid_opr2", alu_opr_2, 32'h7);
        rst = 1'b1;
        gpr_di = 32'h7;
        #1;
        chk("mid_rst_idle", alu_op, 8'hF8);
        step();
        chk("mid_rst_x3", dut.u_gpr.regs_q[3], 32'h11);
        chk("mid_rst_pc", imem_addr, 32'h0);
        rst = 1'b0;
        step();
        step();
        chk("after_rst_x3", dut.u_gpr.regs_q[3], 32'h7);
        chk("after_rst_pc", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
